// File: rtl/dbg_reg_master.sv
// Debug command-to-register-bus master: accepts one read/write command, runs it against a
// register file, returns one response. Define DBG_REG_TIMEOUT_EN to bound the read wait.
module dbg_reg_master #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_REGS       = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   input  logic                  reg_rd_done
);

   if (TIMEOUT_CYCLES < 1 || NUM_REGS < 1 || NUM_REGS > (64'd1 << ADDR_WIDTH))
   begin : g_param_check
      $error("dbg_reg_master: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

   // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] NumRegsL = (ADDR_WIDTH + 1)'(NUM_REGS);

   state_e                state_q;
   logic                  cmd_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  busy_q;
   logic [ADDR_WIDTH-1:0] reg_addr_q;
   logic [DATA_WIDTH-1:0] reg_wr_data_q;
   logic                  reg_wr_en_q;
   logic                  reg_rd_en_q;
   logic                  addr_ok;

`ifdef DBG_REG_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
   logic [CntW-1:0] tmo_cnt_q;
`endif

   always_comb begin
      addr_ok = ({1'b0, cmd_addr_i} < NumRegsL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_rdata_q   <= '0;
         busy_q        <= 1'b0;
         reg_addr_q    <= '0;
         reg_wr_data_q <= '0;
         reg_wr_en_q   <= 1'b0;
         reg_rd_en_q   <= 1'b0;
`ifdef DBG_REG_TIMEOUT_EN
         tmo_cnt_q     <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid_i && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (!addr_ok) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (cmd_write_i) begin
                     state_q       <= StWr;
                     reg_wr_en_q   <= 1'b1;
                     reg_addr_q    <= cmd_addr_i;
                     reg_wr_data_q <= cmd_wdata_i;
                  end else begin
                     state_q     <= StRd;
                     reg_rd_en_q <= 1'b1;
                     reg_addr_q  <= cmd_addr_i;
`ifdef DBG_REG_TIMEOUT_EN
                     tmo_cnt_q   <= '0;
`endif
                  end
               end
            end
            StWr: begin
               reg_wr_en_q <= 1'b0;
               state_q     <= StResp;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            StRd: begin
               // A done strobe in the limit cycle takes priority over the timeout.
               if (reg_rd_done) begin
                  reg_rd_en_q <= 1'b0;
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= reg_rd_data;
               end
`ifdef DBG_REG_TIMEOUT_EN
               else if (tmo_cnt_q == TmoLast) begin
                  reg_rd_en_q <= 1'b0;
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CntW'(1);
               end
`endif
            end
            StResp: begin
               if (rsp_ready_i) begin
                  state_q       <= StIdle;
                  cmd_ready_q   <= 1'b1;
                  rsp_valid_q   <= 1'b0;
                  rsp_err_q     <= 1'b0;
                  rsp_rdata_q   <= '0;
                  busy_q        <= 1'b0;
                  reg_addr_q    <= '0;
                  reg_wr_data_q <= '0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign busy_o      = busy_q;
   assign reg_addr    = reg_addr_q;
   assign reg_wr_data = reg_wr_data_q;
   assign reg_wr_en   = reg_wr_en_q;
   assign reg_rd_en   = reg_rd_en_q;

endmodule

// File: tb/tb_dbg_reg_master.sv
// Scoreboard bench for dbg_reg_master: directed commands push expected responses, a monitor
// checks latency, data and stability of each response against a register-file model.
module tb_dbg_reg_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_write_i = 1'b0;
   logic [7:0]  cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wr_data;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [31:0] reg_rd_data;
   logic        reg_rd_done;

   dbg_reg_master dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .reg_addr    (reg_addr),
      .reg_wr_data (reg_wr_data),
      .reg_wr_en   (reg_wr_en),
      .reg_rd_en   (reg_rd_en),
      .reg_rd_data (reg_rd_data),
      .reg_rd_done (reg_rd_done)
   );

   always #5 clk = ~clk;

   int nvec  = 0;
   int nfail = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Register-file responder: done arrives resp_delay+1 cycles after reg_rd_en rises.
   logic [31:0] regs [0:255];
   logic [31:0] rd_data_q = '0;
   logic        done_q = 1'b0;
   logic        stray_done = 1'b0;
   bit          resp_en = 1'b1;
   int          resp_delay = 0;
   int          rd_age = 0;

   initial for (int i = 0; i < 256; i++) regs[i] = '0;

   always @(posedge clk) begin
      if (reg_wr_en) regs[reg_addr] <= reg_wr_data;
      rd_data_q <= regs[reg_addr];
      rd_age    <= reg_rd_en ? rd_age + 1 : 0;
      done_q    <= reg_rd_en && resp_en && (rd_age == resp_delay);
   end

   assign reg_rd_data = rd_data_q;
   assign reg_rd_done = done_q | stray_done;

   // Bus activity observers.
   int          wr_cnt = 0;
   int          rd_hi_cnt = 0;
   logic [7:0]  last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = reg_addr;
         last_wr_data = reg_wr_data;
      end
      if (reg_rd_en) rd_hi_cnt = rd_hi_cnt + 1;
      nvec++;
      if (reg_wr_en && reg_rd_en) begin
         nfail++;
         $display("FAIL wr_rd_overlap: wr_en=%b rd_en=%b, required not both", reg_wr_en,
                  reg_rd_en);
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   bit   seen = 1'b0;

   // Monitor samples 1 time unit after the falling edge, after the driver has settled.
   always @(negedge clk) begin
      #1;
      if (!rst && rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_rsp: rdata=%h err=%b, required no response",
                     rsp_rdata_o, rsp_err_o);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               nvec++;
               if (cyc - exp_q[0].acc_cyc != exp_q[0].lat) begin
                  nfail++;
                  $display("FAIL rsp_latency: got %0d, required %0d",
                           cyc - exp_q[0].acc_cyc, exp_q[0].lat);
               end
            end
            nvec++;
            if (rsp_rdata_o !== exp_q[0].rdata || rsp_err_o !== exp_q[0].err) begin
               nfail++;
               $display("FAIL rsp_data: rdata=%h err=%b, required rdata=%h err=%b",
                        rsp_rdata_o, rsp_err_o, exp_q[0].rdata, exp_q[0].err);
            end
            if (rsp_ready_i) begin
               void'(exp_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      nvec++;
      if (got !== req) begin
         nfail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic send(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit push,
                       input logic [31:0] er, input bit ee, input int lat);
      int   budget = 0;
      exp_t e;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      while (!cmd_ready_o && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      nvec++;
      if (!cmd_ready_o) begin
         nfail++;
         $display("FAIL cmd_accept: cmd_ready_o=%b after %0d cycles, required 1", cmd_ready_o,
                  budget);
      end else if (push) begin
         e.rdata   = er;
         e.err     = ee;
         e.lat     = lat;
         e.acc_cyc = cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while ((exp_q.size() != 0 || !cmd_ready_o) && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      nvec++;
      if (exp_q.size() != 0 || !cmd_ready_o) begin
         nfail++;
         $display("FAIL wait_idle: pending=%0d cmd_ready_o=%b, required 0 and 1", exp_q.size(),
                  cmd_ready_o);
      end
   endtask

   // One-cycle reset pulse during a stalled read; the transaction must vanish.
   task automatic reset_pulse_check();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_rd", {61'd0, reg_rd_en, rsp_valid_o, busy_o}, 64'd0);
      @(negedge clk);
      check("ready_after_rst", {63'd0, cmd_ready_o}, 64'd1);
   endtask

   initial begin
      int wr0, rd0, good;

      // Reset state, including reg_rd_en held low through reset.
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, reg_wr_en, reg_rd_en, reg_addr},
            64'd0);
      check("reset_data", {rsp_rdata_o, reg_wr_data}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {63'd0, cmd_ready_o}, 64'd1);

      // Write x5 then read it back.
      wr0 = wr_cnt;
      send(1'b1, 8'd5, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2);
      wait_idle();
      check("wr_pulse_count", 64'(wr_cnt - wr0), 64'd1);
      check("wr_pulse_addr_data", {24'd0, last_wr_addr, last_wr_data}, {32'd5, 32'hDEADBEEF});
      check("idle_bus_zero", {24'd0, reg_addr, reg_wr_data}, 64'd0);
      send(1'b0, 8'd5, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);
      send(1'b1, 8'd7, 32'h12345678, 1'b1, 32'h0, 1'b0, 2);
      send(1'b1, 8'd31, 32'hA5A50F0F, 1'b1, 32'h0, 1'b0, 2);
      send(1'b0, 8'd31, 32'h0, 1'b1, 32'hA5A50F0F, 1'b0, 3);
      send(1'b0, 8'd0, 32'h0, 1'b1, 32'h0, 1'b0, 3);
      wait_idle();

      // Out-of-range commands: no bus access, error response one cycle after acceptance.
      wr0 = wr_cnt;
      rd0 = rd_hi_cnt;
      send(1'b0, 8'h40, 32'h0, 1'b1, 32'h0, 1'b1, 1);
      send(1'b1, 8'd32, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1);
      send(1'b0, 8'hFF, 32'h0, 1'b1, 32'h0, 1'b1, 1);
      wait_idle();
      check("range_no_access", {32'(wr_cnt - wr0), 32'(rd_hi_cnt - rd0)}, 64'd0);

      // Back-pressure: response must hold for 10 cycles with no new command accepted.
      rsp_ready_i = 1'b0;
      send(1'b0, 8'd7, 32'h0, 1'b1, 32'h12345678, 1'b0, 3);
      good = 0;
      while (!rsp_valid_o && good < 20) begin
         @(negedge clk);
         good++;
      end
      check("hold_rsp_seen", {63'd0, rsp_valid_o}, 64'd1);
      good = 0;
      repeat (10) begin
         @(negedge clk);
         if (!cmd_ready_o && rsp_valid_o && busy_o) good++;
      end
      check("hold_stable_cycles", 64'(good), 64'd10);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_to_idle", {61'd0, cmd_ready_o, busy_o, rsp_valid_o}, {61'd0, 3'b100});

      // Stray done strobe in IDLE is ignored.
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      check("stray_done_ignored", {62'd0, rsp_valid_o, busy_o}, 64'd0);

`ifdef DBG_REG_TIMEOUT_EN
      // Timeout: 16 cycles of reg_rd_en, then an error response.
      resp_en = 1'b0;
      rd0 = rd_hi_cnt;
      send(1'b0, 8'd31, 32'h0, 1'b1, 32'h0, 1'b1, 17);
      wait_idle();
      check("timeout_rd_en_cycles", 64'(rd_hi_cnt - rd0), 64'd16);
      // Done in the limit cycle wins over the timeout.
      resp_en    = 1'b1;
      resp_delay = 14;
      send(1'b0, 8'd31, 32'h0, 1'b1, 32'hA5A50F0F, 1'b0, 17);
      wait_idle();
      resp_delay = 0;
`else
      // No timeout: the read waits indefinitely.
      resp_en = 1'b0;
      send(1'b0, 8'd31, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      good = 0;
      repeat (100) begin
         @(negedge clk);
         if (reg_rd_en && !rsp_valid_o) good++;
      end
      check("no_timeout_wait", 64'(good), 64'd100);
      reset_pulse_check();
      resp_en = 1'b1;
`endif

      // Reset in the middle of a read, then a normal write/read of x1.
      resp_en = 1'b0;
      send(1'b0, 8'd3, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      repeat (2) @(negedge clk);
      reset_pulse_check();
      resp_en = 1'b1;
      send(1'b1, 8'd1, 32'h00001111, 1'b1, 32'h0, 1'b0, 2);
      send(1'b0, 8'd1, 32'h0, 1'b1, 32'h00001111, 1'b0, 3);
      wait_idle();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
